// File: rtl/seq_stage_ctrl_pkg.sv
// Shared types and constants for the sequential Y86-64 cycle sequencer.
// Provides: FSM state enum, processor status codes, icode constants,
// stage_en bit indices, and helpers for memory-class decode and stage enables.
package seq_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_MEM_WAIT,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // stage_en bit positions (LSB is fetch)
    localparam int EN_F  = 0;
    localparam int EN_D  = 1;
    localparam int EN_E  = 2;
    localparam int EN_M  = 3;
    localparam int EN_W  = 4;
    localparam int EN_PC = 5;

    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
               (ic == IRET)    || (ic == IPUSHQ)  || (ic == IPOPQ);
    endfunction

    // One-hot stage enable driven while the FSM sits in state s.
    function automatic logic [5:0] stage_en_of(input state_e s);
        logic [5:0] en;
        en = '0;
        case (s)
            S_FETCH:     en[EN_F]  = 1'b1;
            S_DECODE:    en[EN_D]  = 1'b1;
            S_EXECUTE:   en[EN_E]  = 1'b1;
            S_MEMORY,
            S_MEM_WAIT:  en[EN_M]  = 1'b1;
            S_WRITEBACK: en[EN_W]  = 1'b1;
            S_PCUPD:     en[EN_PC] = 1'b1;
            default:     en        = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/seq_stage_ctrl_if.sv
// Control/handshake bundle between the cycle sequencer and the Y86-64 datapath.
// master: sequencer side (drives stage_en, mem_req, pc, stat, busy, halted, instr_count).
// slave:  datapath/memory side (drives start, icode, instr_valid, errors, new_pc, mem_ack).
interface seq_stage_ctrl_if;
    logic        start;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] new_pc;
    logic        mem_ack;
    logic        dmem_error;
    logic [5:0]  stage_en;
    logic        mem_req;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        busy;
    logic        halted;
    logic [63:0] instr_count;

    modport master (
        input  start, icode, instr_valid, imem_error, new_pc, mem_ack, dmem_error,
        output stage_en, mem_req, pc, stat, busy, halted, instr_count
    );

    modport slave (
        output start, icode, instr_valid, imem_error, new_pc, mem_ack, dmem_error,
        input  stage_en, mem_req, pc, stat, busy, halted, instr_count
    );
endinterface

// File: rtl/seq_stage_ctrl_mem_wait_timer.sv
// Counts cycles spent waiting for a data-memory ack; flags the last allowed cycle.
// Ports: clk, reset (sync, active-high), clr_i (return to 0), en_i (count), timeout_o.
// timeout_o is high in the MEM_TIMEOUT-th wait cycle (count == MEM_TIMEOUT-1).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign timeout_o = en_i && (cnt_q == 16'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/seq_stage_ctrl.sv
// Cycle sequencer for the sequential Y86-64 core: walks F,D,E,M,W,PC, owns the PC,
// tracks stat and freezes on any non-AOK status. Ports: clk, reset (sync, active-high),
// bus (seq_stage_ctrl_if.master). Optional macro INSTR_COUNT_EN enables instr_count.
module seq_stage_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    seq_stage_ctrl_if.master  bus
);
    state_e      state_q, state_d;
    stat_e       stat_q, stat_d;
    logic [3:0]  icode_q;
    logic [63:0] pc_q;
    logic [5:0]  stage_en_q;
    logic        mem_req_q, mem_req_d;
    logic        busy_q, halted_q;
    logic        timeout;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q != S_MEM_WAIT),
        .en_i      (state_q == S_MEM_WAIT),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        case (state_q)
            S_IDLE:
                if (bus.start) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!bus.instr_valid) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else if (bus.icode == IHALT) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                if (!is_mem_icode(icode_q)) begin
                    state_d = S_WRITEBACK;
                end else if (bus.mem_ack) begin
                    if (bus.dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                // An ack in the final allowed cycle still completes the access.
                if (bus.mem_ack) begin
                    if (bus.dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timeout) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD:     state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase

        // Only EXECUTE leads into MEMORY, so icode_q already holds this instruction.
        mem_req_d = ((state_d == S_MEMORY) && is_mem_icode(icode_q)) ||
                    (state_d == S_MEM_WAIT);
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            stat_q     <= STAT_AOK;
            icode_q    <= '0;
            pc_q       <= RESET_PC;
            stage_en_q <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stat_q     <= stat_d;
            stage_en_q <= stage_en_of(state_d);
            mem_req_q  <= mem_req_d;
            busy_q     <= (state_d != S_IDLE) && (state_d != S_HALT);
            halted_q   <= (state_d == S_HALT);
            if (state_q == S_FETCH)
                icode_q <= bus.icode;
            if (state_q == S_PCUPD)
                pc_q <= bus.new_pc;
        end
    end

`ifdef INSTR_COUNT_EN
    logic [63:0] icount_q;

    // PCUPD always exits to FETCH, so every PCUPD cycle retires one instruction.
    always_ff @(posedge clk) begin
        if (reset)
            icount_q <= '0;
        else if (state_q == S_PCUPD)
            icount_q <= icount_q + 64'd1;
    end

    assign bus.instr_count = icount_q;
`else
    assign bus.instr_count = '0;
`endif

    assign bus.stage_en = stage_en_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.pc       = pc_q;
    assign bus.stat     = stat_q;
    assign bus.busy     = busy_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: one main instance (MEM_TIMEOUT=16, RESET_PC=0)
// and one short-timeout instance (MEM_TIMEOUT=4, RESET_PC=0x100).
// Inputs change 1 time unit after posedge; outputs are checked at the same point.
module tb_seq_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m;
    logic rst_t;

    seq_stage_ctrl_if bm();
    seq_stage_ctrl_if bt();

    seq_stage_ctrl #(.RESET_PC(64'h0), .MEM_TIMEOUT(16)) u_main (
        .clk   (clk),
        .reset (rst_m),
        .bus   (bm)
    );

    seq_stage_ctrl #(.RESET_PC(64'h100), .MEM_TIMEOUT(4)) u_to (
        .clk   (clk),
        .reset (rst_t),
        .bus   (bt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Common check of the main instance's stage enable, request and status.
    task automatic chk_m(input string tag, input logic [5:0] en, input logic req,
                         input logic [2:0] st);
        chk({tag, ".stage_en"}, bm.stage_en, en);
        chk({tag, ".mem_req"},  bm.mem_req,  req);
        chk({tag, ".stat"},     bm.stat,     st);
    endtask

    logic [5:0] walk [6];

    initial begin
        walk[0] = 6'h01; walk[1] = 6'h02; walk[2] = 6'h04;
        walk[3] = 6'h08; walk[4] = 6'h10; walk[5] = 6'h20;

        rst_m = 1'b1; rst_t = 1'b1;
        bm.start = 0; bm.icode = 4'h6; bm.instr_valid = 1; bm.imem_error = 0;
        bm.new_pc = 64'h2; bm.mem_ack = 0; bm.dmem_error = 0;
        bt.start = 0; bt.icode = 4'h5; bt.instr_valid = 1; bt.imem_error = 0;
        bt.new_pc = 64'h300; bt.mem_ack = 0; bt.dmem_error = 0;
        tick(); tick();

        // Reset state
        chk_m("rst", 6'h00, 1'b0, 3'd1);
        chk("rst.pc", bm.pc, 64'h0);
        chk("rst.busy", bm.busy, 1'b0);
        chk("rst.halted", bm.halted, 1'b0);
        chk("rst.icount", bm.instr_count, 64'h0);
        chk("rst_to.pc", bt.pc, 64'h100);

        // Non-memory instruction: OPq, six cycles
        rst_m = 0; bm.start = 1;
        tick();
        bm.start = 0;
        chk_m("opq.F", walk[0], 1'b0, 3'd1);
        chk("opq.busy", bm.busy, 1'b1);
        for (int i = 1; i < 6; i++) begin
            tick();
            chk_m($sformatf("opq.s%0d", i), walk[i], 1'b0, 3'd1);
            chk($sformatf("opq.pc%0d", i), bm.pc, 64'h0);
        end
        tick();
        chk_m("opq.next", 6'h01, 1'b0, 3'd1);
        chk("opq.pc", bm.pc, 64'h2);

        // mrmovq with ack in third memory cycle: M + 2 MEM_WAIT
        bm.icode = 4'h5; bm.new_pc = 64'h20;
        tick(); chk_m("mr.D", 6'h02, 1'b0, 3'd1);
        tick(); chk_m("mr.E", 6'h04, 1'b0, 3'd1);
        tick(); chk_m("mr.M", 6'h08, 1'b1, 3'd1);
        tick(); chk_m("mr.W1", 6'h08, 1'b1, 3'd1);
        tick(); chk_m("mr.W2", 6'h08, 1'b1, 3'd1);
        bm.mem_ack = 1;
        tick(); chk_m("mr.WB", 6'h10, 1'b0, 3'd1);
        bm.mem_ack = 0;
        tick(); chk_m("mr.PC", 6'h20, 1'b0, 3'd1);
        chk("mr.pc_hold", bm.pc, 64'h2);
        tick(); chk_m("mr.F", 6'h01, 1'b0, 3'd1);
        chk("mr.pc", bm.pc, 64'h20);

        // halt instruction
        bm.icode = 4'h0;
        tick();
        chk_m("hlt", 6'h00, 1'b0, 3'd2);
        chk("hlt.halted", bm.halted, 1'b1);
        chk("hlt.busy", bm.busy, 1'b0);
        chk("hlt.pc", bm.pc, 64'h20);
        bm.start = 1;
        tick(); tick();
        bm.start = 0;
        chk("hlt.start_ign", bm.halted, 1'b1);
        chk_m("hlt.frozen", 6'h00, 1'b0, 3'd2);
        rst_m = 1;
        tick();
        rst_m = 0;
        chk("hlt.rst_pc", bm.pc, 64'h0);
        chk("hlt.rst_stat", bm.stat, 3'd1);
        chk("hlt.rst_halted", bm.halted, 1'b0);

        // Illegal instruction
        bm.icode = 4'h6; bm.instr_valid = 0; bm.start = 1;
        tick(); bm.start = 0;
        tick();
        chk("ins.stat", bm.stat, 3'd4);
        chk("ins.halted", bm.halted, 1'b1);

        // Fetch address error wins over illegal instruction
        rst_m = 1; tick(); rst_m = 0;
        bm.imem_error = 1; bm.start = 1;
        tick(); bm.start = 0;
        tick();
        chk("imem.stat", bm.stat, 3'd3);
        chk("imem.halted", bm.halted, 1'b1);
        bm.imem_error = 0; bm.instr_valid = 1;

        // Data-memory error on first-cycle ack of pushq
        rst_m = 1; tick(); rst_m = 0;
        bm.icode = 4'hA; bm.new_pc = 64'h55; bm.start = 1;
        tick(); bm.start = 0;
        tick(); tick(); tick();
        chk_m("dme.M", 6'h08, 1'b1, 3'd1);
        bm.mem_ack = 1; bm.dmem_error = 1;
        tick();
        bm.mem_ack = 0; bm.dmem_error = 0;
        chk_m("dme.halt", 6'h00, 1'b0, 3'd3);
        chk("dme.pc", bm.pc, 64'h0);
        tick();
        chk("dme.noW", bm.stage_en, 6'h00);

        // Three OPq instructions then halt
        rst_m = 1; tick(); rst_m = 0;
        bm.icode = 4'h6; bm.new_pc = 64'h9; bm.start = 1;
        tick(); bm.start = 0;
        for (int i = 0; i < 18; i++) tick();
        chk("cnt.F", bm.stage_en, 6'h01);
        bm.icode = 4'h0;
        tick();
        chk("cnt.halted", bm.halted, 1'b1);
`ifdef INSTR_COUNT_EN
        chk("cnt.icount", bm.instr_count, 64'd3);
`else
        chk("cnt.icount", bm.instr_count, 64'd0);
`endif

        // Reset while in MEM_WAIT
        rst_m = 1; tick(); rst_m = 0;
        bm.icode = 4'h5; bm.start = 1;
        tick(); bm.start = 0;
        tick(); tick(); tick(); tick();
        chk_m("rmw.wait", 6'h08, 1'b1, 3'd1);
        rst_m = 1;
        tick();
        rst_m = 0;
        chk_m("rmw.idle", 6'h00, 1'b0, 3'd1);
        chk("rmw.busy", bm.busy, 1'b0);
        chk("rmw.icount", bm.instr_count, 64'd0);

        // Timeout instance: no ack, ADR after four MEM_WAIT cycles
        rst_t = 0; bt.start = 1;
        tick(); bt.start = 0;
        tick(); tick(); tick();
        chk("to.M.req", bt.mem_req, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to.wait%0d.req", i), bt.mem_req, 1'b1);
            chk($sformatf("to.wait%0d.halted", i), bt.halted, 1'b0);
        end
        tick();
        chk("to.stat", bt.stat, 3'd3);
        chk("to.halted", bt.halted, 1'b1);
        chk("to.req", bt.mem_req, 1'b0);
        chk("to.pc", bt.pc, 64'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
